memory_bus_arbiter: RTL and testbench

- Shares one downstream MemoryBus (DRAM/cache side) between NUM_REQ upstream requesters, e.g. instruction fetch and load/store.
- Round-robin grant with one outstanding transaction at a time.
- Forwards the granted request packet downstream, waits for the read response, and routes it back to the requester named in the packet source field.
- Writes complete on downstream accept; they produce no response.

---
 rtl/memory_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one downstream memory bus between NUM_REQ requesters, one transaction in flight.
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN (adds the timeout_err port).
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no transaction; grant the next pending requester round-robin
// ISSUE     | request presented downstream, waiting for dn_req_accept
// WAIT_RESP | read issued, waiting for the downstream response
// DELIVER   | response held for the granted requester until it takes it
module memory_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int PKT_W          = 2 + ID_W + ADDR_W + DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       up_req_busy,
    input  logic [NUM_REQ*PKT_W-1:0] up_req_data,
    output logic [NUM_REQ-1:0]       up_req_accept,
    output logic [NUM_REQ-1:0]       up_resp_busy,
    output logic [PKT_W-1:0]         up_resp_data,
    input  logic [NUM_REQ-1:0]       up_resp_take,
    output logic                     dn_req_busy,
    output logic [PKT_W-1:0]         dn_req_data,
    input  logic                     dn_req_accept,
    input  logic                     dn_resp_busy,
    input  logic [PKT_W-1:0]         dn_resp_data,
    output logic                     dn_resp_take,
    output logic [ID_W-1:0]          grant_id
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int SRC_LSB  = ADDR_W + DATA_W;
    localparam int TYPE_LSB = ID_W + ADDR_W + DATA_W;
    localparam int EXT_W    = 1 << ID_W;

    localparam logic [1:0] PT_WRITE = 2'd1;
    localparam logic [1:0] PT_RESP  = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || NUM_REQ > EXT_W || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("memory_bus_arbiter: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DELIVER   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    g_q, g_d;
    logic [PKT_W-1:0]   req_pkt_q, req_pkt_d;
    logic [PKT_W-1:0]   resp_pkt_q, resp_pkt_d;

    logic [EXT_W-1:0]   busy_ext;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic [PKT_W-1:0]   sel_pkt;
    logic [NUM_REQ-1:0] g_onehot;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] cnt_q;
    logic            to_fire;
    logic            timeout_q;
`endif

    assign busy_ext = EXT_W'(up_req_busy);
    assign g_onehot = NUM_REQ'(1) << g_q;

    // First pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && busy_ext[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == ID_W'(i)) begin
                sel_pkt = up_req_data[i*PKT_W +: PKT_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        g_d           = g_q;
        req_pkt_d     = req_pkt_q;
        resp_pkt_d    = resp_pkt_q;
        up_req_accept = '0;
        dn_resp_take  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_fire       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    up_req_accept = NUM_REQ'(1) << pick;
                    g_d           = pick;
                    req_pkt_d     = sel_pkt;
                    // The requester's own source field is not trusted.
                    req_pkt_d[SRC_LSB +: ID_W] = pick;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (dn_req_accept) begin
                    rr_d    = (g_q == ID_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                    state_d = (req_pkt_q[TYPE_LSB +: 2] == PT_WRITE) ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (dn_resp_busy) begin
                    dn_resp_take = 1'b1;
                    resp_pkt_d   = dn_resp_data;
                    state_d      = DELIVER;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_pkt_d = {PT_RESP, g_q, {ADDR_W{1'b0}}, {DATA_W{1'b1}}};
                    to_fire    = 1'b1;
                    state_d    = DELIVER;
                end
`endif
            end
            DELIVER: begin
                if (|(up_resp_take & g_onehot)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake pulses must stay quiet while reset is held.
        if (reset) begin
            up_req_accept = '0;
            dn_resp_take  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            g_q        <= '0;
            req_pkt_q  <= '0;
            resp_pkt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            g_q        <= g_d;
            req_pkt_q  <= req_pkt_d;
            resp_pkt_q <= resp_pkt_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == WAIT_RESP) ? cnt_q + 1'b1 : '0;
            timeout_q <= to_fire;
        end
    end

    assign timeout_err = timeout_q;
`endif

    // Misrouted or mistyped responses are still delivered to the granted requester.
    always_ff @(posedge clk) begin
        if (!reset && state_q == WAIT_RESP && dn_resp_busy) begin
            assert (dn_resp_data[SRC_LSB +: ID_W] == g_q && dn_resp_data[TYPE_LSB +: 2] == PT_RESP);
        end
    end

    assign dn_req_busy  = (state_q == ISSUE);
    assign dn_req_data  = req_pkt_q;
    assign up_resp_busy = (state_q == DELIVER) ? g_onehot : '0;
    assign up_resp_data = resp_pkt_q;
    assign grant_id     = g_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized self-checking bench for memory_bus_arbiter (NUM_REQ=3) against a transaction-level model.
module tb_memory_bus_arbiter;

    localparam int NR  = 3;
    localparam int IDW = 3;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int PW  = 2 + IDW + AW + DW;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     up_req_busy;
    logic [NR*PW-1:0]  up_req_data;
    logic [NR-1:0]     up_req_accept;
    logic [NR-1:0]     up_resp_busy;
    logic [PW-1:0]     up_resp_data;
    logic [NR-1:0]     up_resp_take;
    logic              dn_req_busy;
    logic [PW-1:0]     dn_req_data;
    logic              dn_req_accept;
    logic              dn_resp_busy;
    logic [PW-1:0]     dn_resp_data;
    logic              dn_resp_take;
    logic [IDW-1:0]    grant_id;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int rr_m     = 0;

    memory_bus_arbiter #(
        .NUM_REQ(NR), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .PKT_W(PW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .up_req_busy(up_req_busy), .up_req_data(up_req_data), .up_req_accept(up_req_accept),
        .up_resp_busy(up_resp_busy), .up_resp_data(up_resp_data), .up_resp_take(up_resp_take),
        .dn_req_busy(dn_req_busy), .dn_req_data(dn_req_data), .dn_req_accept(dn_req_accept),
        .dn_resp_busy(dn_resp_busy), .dn_resp_data(dn_resp_data), .dn_resp_take(dn_resp_take),
        .grant_id(grant_id)
`ifdef MEM_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input logic [1:0] t, input logic [IDW-1:0] s,
                                             input logic [AW-1:0] a, input logic [DW-1:0] p);
        return {t, s, a, p};
    endfunction

    // Rotate the pending mask so the pointer sits at bit 0, then take the lowest set bit.
    function automatic int model_pick(input int rr, input logic [NR-1:0] mask);
        logic [2*NR-1:0] dbl;
        dbl = {mask, mask} >> rr;
        for (int j = 0; j < NR; j++) begin
            if (dbl[j]) return (rr + j) % NR;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        up_req_busy   = '0;
        up_req_data   = '0;
        up_resp_take  = '0;
        dn_req_accept = 1'b0;
        dn_resp_busy  = 1'b0;
        dn_resp_data  = '0;
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_accept"},  128'(up_req_accept), 128'(0));
        check_val({tag, "_respbsy"}, 128'(up_resp_busy),  128'(0));
        check_val({tag, "_dnbusy"},  128'(dn_req_busy),   128'(0));
        check_val({tag, "_dntake"},  128'(dn_resp_take),  128'(0));
        check_val({tag, "_dndata"},  128'(dn_req_data),   128'(0));
        check_val({tag, "_respdat"}, 128'(up_resp_data),  128'(0));
        check_val({tag, "_grant"},   128'(grant_id),      128'(0));
    endtask

    // One complete transaction: grant, downstream issue with stall, optional read response and delivery.
    task automatic do_txn(input logic [NR-1:0] mask, input int stall, input int dly,
                          input bit early, input int fty);
        logic [PW-1:0] pk [NR];
        logic [PW-1:0] exp_dn;
        logic [PW-1:0] resp;
        logic [1:0]    ty;
        logic [NR-1:0] oh;
        int            g;
        for (int i = 0; i < NR; i++) begin
            ty    = (fty < 0) ? 2'($urandom_range(0, 1)) : 2'(fty);
            pk[i] = mk_pkt(ty, IDW'($urandom), AW'($urandom), {$urandom, $urandom});
        end
        g      = model_pick(rr_m, mask);
        oh     = NR'(1) << g;
        exp_dn = pk[g];
        exp_dn[AW+DW +: IDW] = IDW'(g);
        ty     = pk[g][PW-1 -: 2];
        resp   = mk_pkt(2'd2, IDW'(g), AW'($urandom), {$urandom, $urandom});

        @(negedge clk);
        up_req_busy = mask;
        for (int i = 0; i < NR; i++) up_req_data[i*PW +: PW] = pk[i];
        #1;
        check_val("grant_accept", 128'(up_req_accept), 128'(oh));
        check_val("dn_busy_idle", 128'(dn_req_busy), 128'(0));

        for (int c = 0; c <= stall; c++) begin
            @(negedge clk);
            up_req_busy   = mask & ~oh;
            dn_req_accept = (c == stall);
            if (c == stall && early && ty == 2'd0) begin
                dn_resp_busy = 1'b1;
                dn_resp_data = resp;
            end
            #1;
            check_val("issue_busy",   128'(dn_req_busy),   128'(1));
            check_val("issue_data",   128'(dn_req_data),   128'(exp_dn));
            check_val("issue_noacc",  128'(up_req_accept), 128'(0));
            check_val("issue_grant",  128'(grant_id),      128'(g));
            check_val("issue_notake", 128'(dn_resp_take),  128'(0));
        end
        rr_m = (g + 1) % NR;

        @(negedge clk);
        dn_req_accept = 1'b0;
        up_req_busy   = '0;
        #1;
        check_val("post_issue_busy", 128'(dn_req_busy), 128'(0));
        if (ty == 2'd1) begin
            check_val("write_notake", 128'(dn_resp_take), 128'(0));
            check_val("write_noresp", 128'(up_resp_busy), 128'(0));
        end else begin
            if (early) dly = 0;
            for (int c = 0; c <= dly; c++) begin
                if (c > 0) @(negedge clk);
                if (c == dly) begin
                    dn_resp_busy = 1'b1;
                    dn_resp_data = resp;
                end
                #1;
                check_val("wait_take",   128'(dn_resp_take), 128'(c == dly));
                check_val("wait_noresp", 128'(up_resp_busy), 128'(0));
            end
            @(negedge clk);
            dn_resp_busy = 1'b0;
            dn_resp_data = mk_pkt(2'd3, IDW'($urandom), AW'($urandom), {$urandom, $urandom});
            #1;
            check_val("deliver_busy",   128'(up_resp_busy), 128'(oh));
            check_val("deliver_data",   128'(up_resp_data), 128'(resp));
            check_val("deliver_notake", 128'(dn_resp_take), 128'(0));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                up_resp_take = NR'($urandom) & ~oh;
                #1;
                check_val("deliver_hold", 128'(up_resp_busy), 128'(oh));
            end
            @(negedge clk);
            up_resp_take = oh;
            #1;
            check_val("deliver_take", 128'(up_resp_busy), 128'(oh));
            @(negedge clk);
            up_resp_take = '0;
            #1;
            check_val("deliver_clear", 128'(up_resp_busy), 128'(0));
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;

        do_txn(3'b001, 0, 3, 1'b0, 0);
        do_txn(3'b010, 2, 0, 1'b0, 1);
        repeat (4) do_txn(3'b111, 0, 0, 1'b0, 0);
        do_txn(3'b011, 10, 1, 1'b0, 0);
        do_txn(3'b110, 1, 0, 1'b1, 0);
        repeat (60) begin
            do_txn(NR'($urandom_range(1, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), -1);
        end

        // Abandon a read in WAIT_RESP with a reset and a late response.
        @(negedge clk);
        up_req_busy = 3'b010;
        up_req_data[PW +: PW] = mk_pkt(2'd0, 3'd5, 32'h0000_0200, 64'd0);
        #1;
        check_val("rst_seq_accept", 128'(up_req_accept), 128'(3'b010));
        @(negedge clk);
        up_req_busy   = '0;
        dn_req_accept = 1'b1;
        #1;
        check_val("rst_seq_issue", 128'(dn_req_busy), 128'(1));
        @(negedge clk);
        dn_req_accept = 1'b0;
        #1;
        check_val("rst_seq_wait", 128'(dn_req_busy), 128'(0));
        @(negedge clk);
        reset        = 1'b1;
        dn_resp_busy = 1'b1;
        dn_resp_data = mk_pkt(2'd2, 3'd1, 32'h0000_0200, 64'h1234);
        #1;
        check_val("rst_take_gated", 128'(dn_resp_take), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        dn_resp_busy = 1'b0;
        #1;
        check_val("late_resp_ignored", 128'(dn_resp_take), 128'(0));
        rr_m = 0;
        do_txn(3'b101, 0, 1, 1'b0, 0);
        do_txn(3'b100, 0, 1, 1'b0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge clk);
        up_req_busy = 3'b001;
        up_req_data[0 +: PW] = mk_pkt(2'd0, 3'd0, 32'h0000_0100, 64'd0);
        #1;
        check_val("to_accept", 128'(up_req_accept), 128'(3'b001));
        @(negedge clk);
        up_req_busy   = '0;
        dn_req_accept = 1'b1;
        #1;
        rr_m = 1;
        @(negedge clk);
        dn_req_accept = 1'b0;
        for (int c = 0; c < TO; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            check_val("to_wait_err",  128'(timeout_err),  128'(0));
            check_val("to_wait_resp", 128'(up_resp_busy), 128'(0));
        end
        @(negedge clk);
        #1;
        check_val("to_err_pulse", 128'(timeout_err),  128'(1));
        check_val("to_resp_busy", 128'(up_resp_busy), 128'(3'b001));
        check_val("to_resp_data", 128'(up_resp_data),
                  128'(mk_pkt(2'd2, 3'd0, 32'd0, {DW{1'b1}})));
        @(negedge clk);
        up_resp_take = 3'b001;
        #1;
        check_val("to_err_single", 128'(timeout_err), 128'(0));
        @(negedge clk);
        up_resp_take = '0;
        #1;
        check_val("to_clear", 128'(up_resp_busy), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
